// File: rtl/seq_mag_compare.sv
// Chunk-serial magnitude comparator: compares A and B MSB-chunk first, CHUNK bits
// per cycle, stopping at the first differing chunk. Supports unsigned and signed compare.
module seq_mag_compare #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);
  localparam logic [CW-1:0] NCHUNK_C = CW'(NCHUNK);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t state, state_nxt;

  logic [NCHUNK-1:0][CHUNK-1:0] a_ch, b_ch;
  logic                         sgn_r;
  logic [IW-1:0]                idx;
  logic [CHUNK-1:0]             ca, cb;
  logic                         flip_top;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [CHUNK-1:0] bias_chunk(input logic [CHUNK-1:0] c,
                                                  input logic flip);
    logic [CHUNK-1:0] m;
    m = '0;
    m[CHUNK-1] = flip;
    return c ^ m;
  endfunction

  always_comb begin
    flip_top = sgn_r && (idx == TOP_IDX);
    ca = bias_chunk(a_ch[idx], flip_top);
    cb = bias_chunk(b_ch[idx], flip_top);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CMP;
      end
      CMP: begin
        if ((ca != cb) || (idx == '0)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_ch  <= a;
      b_ch  <= b;
      sgn_r <= is_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      cycles <= '0;
      idx    <= TOP_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gt  <= 1'b0;
            eq  <= 1'b0;
            lt  <= 1'b0;
            idx <= TOP_IDX;
          end
        end
        CMP: begin
          if (ca != cb) begin
            gt     <= (ca > cb);
            lt     <= (ca < cb);
            cycles <= NCHUNK_C - CW'(idx);
          end else if (idx == '0) begin
            eq     <= 1'b1;
            cycles <= NCHUNK_C;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Scoreboard bench for seq_mag_compare: an 8-bit/2-bit instance for directed vectors
// and a 2-bit/2-bit instance swept over all operand pairs.
module tb_seq_mag_compare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
    logic [2:0] cyc;
  } exp_t;

  logic       reset, start8, sg8, start2, sg2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       ready8, done8, gt8, eq8, lt8;
  logic [2:0] cyc8;
  logic       ready2, done2, gt2, eq2, lt2;
  logic [0:0] cyc2;

  seq_mag_compare #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sg8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8), .cycles(cyc8)
  );

  seq_mag_compare #(.WIDTH(2), .CHUNK(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .is_signed(sg2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2), .cycles(cyc2)
  );

  exp_t q8[$];
  exp_t q2[$];
  int   done_t8[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick = 0;

  always @(posedge clk) tick <= tick + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      done_t8.push_back(tick);
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done8: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        check("result8", {26'd0, gt8, eq8, lt8, cyc8}, {26'd0, e});
        check("onehot8", 32'(gt8) + 32'(eq8) + 32'(lt8), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      exp_t e;
      if (q2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done2: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = q2.pop_front();
        check("result2", {26'd0, gt2, eq2, lt2, 2'b00, cyc2}, {26'd0, e});
      end
    end
  end

  task automatic wait_ready8();
    int k = 0;
    @(negedge clk);
    while (!(ready8 && q8.size() == 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready8) check("timeout_ready8", 32'(ready8), 32'd1);
  endtask

  task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic s, input exp_t e);
    wait_ready8();
    a8 = va; b8 = vb; sg8 = s; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] va, input logic [1:0] vb, input exp_t e);
    int k = 0;
    @(negedge clk);
    while (!ready2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready2) check("timeout_ready2", 32'(ready2), 32'd1);
    a2 = va; b2 = vb; sg2 = 1'b0; start2 = 1'b1;
    q2.push_back(e);
    @(posedge clk);
    #1 start2 = 1'b0;
  endtask

  initial begin
    int k;
    int nd;
    reset = 1'b1; start8 = 1'b0; start2 = 1'b0; sg8 = 1'b0; sg2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_flags", {29'd0, gt8, eq8, lt8}, 32'd0);
    check("rst_cycles", 32'(cyc8), 32'd0);
    reset = 1'b0;

    // directed vectors, expected {gt,eq,lt,cycles}
    issue8(8'hC3, 8'h43, 1'b0, '{1'b1, 1'b0, 1'b0, 3'd1});
    issue8(8'hA5, 8'hA5, 1'b0, '{1'b0, 1'b1, 1'b0, 3'd4});
    issue8(8'h10, 8'h11, 1'b0, '{1'b0, 1'b0, 1'b1, 3'd4});
    issue8(8'hFF, 8'h01, 1'b1, '{1'b0, 1'b0, 1'b1, 3'd1});
    issue8(8'hFF, 8'h01, 1'b0, '{1'b1, 1'b0, 1'b0, 3'd1});
    issue8(8'h80, 8'h7F, 1'b1, '{1'b0, 1'b0, 1'b1, 3'd1});
    issue8(8'h34, 8'h38, 1'b0, '{1'b0, 1'b0, 1'b1, 3'd3});
    issue8(8'hFE, 8'hFD, 1'b1, '{1'b1, 1'b0, 1'b0, 3'd4});

    // start while busy and operand changes mid-compare must be ignored
    issue8(8'h10, 8'h11, 1'b0, '{1'b0, 1'b0, 1'b1, 3'd4});
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; sg8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;

    // start held high: back-to-back ops spaced m+2 cycles
    wait_ready8();
    done_t8.delete();
    a8 = 8'h34; b8 = 8'h38; sg8 = 1'b0;
    repeat (3) q8.push_back('{1'b0, 1'b0, 1'b1, 3'd3});
    start8 = 1'b1;
    k = 0;
    while (done_t8.size() < 3 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    start8 = 1'b0;
    check("held_done_count", 32'(done_t8.size()), 32'd3);
    if (done_t8.size() >= 3) begin
      check("spacing_1", 32'(done_t8[1] - done_t8[0]), 32'd5);
      check("spacing_2", 32'(done_t8[2] - done_t8[1]), 32'd5);
    end

    // results hold after done
    wait_ready8();
    repeat (3) @(negedge clk);
    check("hold_result", {26'd0, gt8, eq8, lt8, cyc8}, {26'd0, 3'b001, 3'd3});

    // reset two cycles after accepting a=b=0 aborts without a done pulse
    wait_ready8();
    nd = done_t8.size();
    a8 = 8'h00; b8 = 8'h00; sg8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 32'(ready8), 32'd1);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_flags", {29'd0, gt8, eq8, lt8}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_pulse", 32'(done_t8.size()), 32'(nd));

    // WIDTH=CHUNK: all pairs finish in one chunk
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        issue2(2'(i), 2'(j), '{(i > j), (i == j), (i < j), 3'd1});
      end
    end

    k = 0;
    while ((q8.size() != 0 || q2.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_q8", 32'(q8.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
